fcmp_pipe: RTL and testbench

- Pipelined, handshaked floating-point compare unit for the FPU issue path.
- Executes the RISC-V-style FEQ.S, FLT.S and FLE.S compares on IEEE-754 binary32 operands. Returns a 32-bit integer result (0 or 1) plus an invalid-operation flag.
- Sits between the FPU dispatch stage (producer) and the integer writeback arbiter (consumer).
- Covers the ordering compares (less-than, less-or-equal) as well as equality. Uses full valid/ready flow control.

---
 rtl/fpu_cmp_pkg.sv | 35 +++
 rtl/fcmp_core.sv | 56 +++++
 rtl/fcmp_pipe.sv | 99 +++++++++
 tb/tb_fcmp_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cmp_pkg.sv
// Shared types and classification helper for the binary32 compare pipeline.
package fpu_cmp_pkg;

    typedef enum logic [1:0] {
        FCMP_FLE = 2'b00,
        FCMP_FLT = 2'b01,
        FCMP_FEQ = 2'b10
    } fcmp_op_e;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
    localparam int         QNAN_BIT     = 22;

    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_nan;
        logic is_snan;
        logic is_inf;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        logic      exp_ones;
        logic      mant_nz;
        exp_ones  = (x[30:23] == EXP_ALL_ONES);
        mant_nz   = |x[22:0];
        c.sign    = x[31];
        c.is_zero = ~|x[30:0];
        c.is_nan  = exp_ones & mant_nz;
        c.is_snan = exp_ones & mant_nz & ~x[QNAN_BIT];
        c.is_inf  = exp_ones & ~mant_nz;
        return c;
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational FEQ/FLT/FLE evaluation on pre-classified binary32 operands.
module fcmp_core
    import fpu_cmp_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] x1_i,
    input  logic [31:0] x2_i,
    input  fp_class_t   c1_i,
    input  fp_class_t   c2_i,
    output logic        cmp_o,
    output logic        nv_o
);

    logic any_nan;
    logic any_snan;
    logic both_zero;
    logic eq;
    logic lt;

    always_comb begin
        any_nan   = c1_i.is_nan | c2_i.is_nan;
        any_snan  = c1_i.is_snan | c2_i.is_snan;
        both_zero = c1_i.is_zero & c2_i.is_zero;
        eq        = both_zero | (x1_i == x2_i)
                  | (c1_i.is_inf & c2_i.is_inf & (c1_i.sign == c2_i.sign));

        // Sign-magnitude order: {exp, mant} compares as unsigned, reversed when negative.
        if (both_zero)
            lt = 1'b0;
        else if (c1_i.sign != c2_i.sign)
            lt = c1_i.sign;
        else if (c1_i.sign)
            lt = (x1_i[30:0] > x2_i[30:0]);
        else
            lt = (x1_i[30:0] < x2_i[30:0]);

        cmp_o = 1'b0;
        nv_o  = 1'b0;
        case (fcmp_op_e'(op_i))
            FCMP_FEQ: begin
                cmp_o = ~any_nan & eq;
                nv_o  = any_snan;
            end
            FCMP_FLT: begin
                cmp_o = ~any_nan & lt;
                nv_o  = any_nan;
            end
            FCMP_FLE: begin
                cmp_o = ~any_nan & (lt | eq);
                nv_o  = any_nan;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage valid/ready binary32 compare unit: S1 holds operands and class, S2 the result.
module fcmp_pipe
    import fpu_cmp_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q;
    logic [31:0]      s1_x1_q;
    logic [31:0]      s1_x2_q;
    logic [TAG_W-1:0] s1_tag_q;
    fp_class_t        s1_c1_q;
    fp_class_t        s1_c2_q;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_cmp_q;
    logic             s2_nv_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic s2_ready;
    logic s1_load;
    logic s2_load;
    logic core_cmp;
    logic core_nv;

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && s2_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_ready)
            s1_valid_d = in_valid;
        if (s2_ready)
            s2_valid_d = s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_op_q  <= in_op;
            s1_x1_q  <= in_x1;
            s1_x2_q  <= in_x2;
            s1_tag_q <= in_tag;
            s1_c1_q  <= fp_classify(in_x1);
            s1_c2_q  <= fp_classify(in_x2);
        end
    end

    fcmp_core u_core (
        .op_i  (s1_op_q),
        .x1_i  (s1_x1_q),
        .x2_i  (s1_x2_q),
        .c1_i  (s1_c1_q),
        .c2_i  (s1_c2_q),
        .cmp_o (core_cmp),
        .nv_o  (core_nv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_cmp_q   <= 1'b0;
            s2_nv_q    <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                s2_cmp_q <= core_cmp;
                s2_nv_q  <= core_nv;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_y     = {31'b0, s2_cmp_q};
    assign out_nv    = s2_nv_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed-vector bench for fcmp_pipe: compare semantics, latency, backpressure and reset.
module tb_fcmp_pipe;

    localparam logic [1:0] OP_FLE = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FEQ = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        y;
        logic        nv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_x1;
    logic [31:0] in_x2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_nv;
    logic [4:0]  out_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fcmp_pipe #(.TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_nv    (out_nv),
        .out_tag   (out_tag)
    );

    // Issues one op into an idle pipe and waits (bounded) for its result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] y, output logic nv,
                          output logic [4:0] tg, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_x1     = a;
        in_x2     = b;
        in_tag    = t;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        y  = out_y;
        nv = out_nv;
        tg = out_tag;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_x1     = '0;
        in_x2     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_y !== 32'h0 || out_nv !== 1'b0 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b y=%0h nv=%0b tag=%0d, want 0 0 0 0",
                     out_valid, out_y, out_nv, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] y;
        logic        nv;
        logic [4:0]  tg;
        int          lat;
        run_op(OP_FEQ, 32'h3F800000, 32'h3F800000, 5'd3, y, nv, tg, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, want 2", lat);
        end
        checks++;
        if (y !== 32'h1 || nv !== 1'b0 || tg !== 5'd3) begin
            errors++;
            $display("FAIL basic_feq: got y=%0h nv=%0b tag=%0d, want y=1 nv=0 tag=3", y, nv, tg);
        end
    endtask

    task automatic test_signed_zero();
        vec_t        v[3];
        logic [31:0] y;
        logic        nv;
        logic [4:0]  tg;
        int          lat;
        v[0] = '{OP_FEQ, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
        v[1] = '{OP_FLT, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
        v[2] = '{OP_FLE, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, 5'(i + 4), y, nv, tg, lat);
            checks++;
            if (y !== {31'b0, v[i].y} || nv !== v[i].nv || tg !== 5'(i + 4)) begin
                errors++;
                $display("FAIL signed_zero[%0d]: got y=%0h nv=%0b tag=%0d, want y=%0h nv=%0b tag=%0d",
                         i, y, nv, tg, {31'b0, v[i].y}, v[i].nv, i + 4);
            end
        end
        // FLT(-0,+0) and FLE(-0,+0)
        run_op(OP_FLT, 32'h80000000, 32'h00000000, 5'd7, y, nv, tg, lat);
        checks++;
        if (y !== 32'h0 || nv !== 1'b0) begin
            errors++;
            $display("FAIL flt_negzero_poszero: got y=%0h nv=%0b, want y=0 nv=0", y, nv);
        end
        run_op(OP_FLE, 32'h80000000, 32'h00000000, 5'd7, y, nv, tg, lat);
        checks++;
        if (y !== 32'h1 || nv !== 1'b0) begin
            errors++;
            $display("FAIL fle_negzero_poszero: got y=%0h nv=%0b, want y=1 nv=0", y, nv);
        end
    endtask

    task automatic test_ordering();
        vec_t        v[8];
        logic [31:0] y;
        logic        nv;
        logic [4:0]  tg;
        int          lat;
        v[0] = '{OP_FLT, 32'hBF800000, 32'h3F800000, 1'b1, 1'b0};
        v[1] = '{OP_FLT, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0};
        v[2] = '{OP_FLE, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0};
        v[3] = '{OP_FLT, 32'h00000001, 32'h00000002, 1'b1, 1'b0};
        v[4] = '{OP_FLT, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0};
        v[5] = '{OP_FLT, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0};
        v[6] = '{OP_FLE, 32'h40000000, 32'h3F800000, 1'b0, 1'b0};
        v[7] = '{OP_FLT, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, 5'(i + 8), y, nv, tg, lat);
            checks++;
            if (y !== {31'b0, v[i].y} || nv !== v[i].nv || tg !== 5'(i + 8)) begin
                errors++;
                $display("FAIL ordering[%0d]: got y=%0h nv=%0b tag=%0d, want y=%0h nv=%0b tag=%0d",
                         i, y, nv, tg, {31'b0, v[i].y}, v[i].nv, i + 8);
            end
        end
    endtask

    task automatic test_nan();
        vec_t        v[5];
        logic [31:0] y;
        logic        nv;
        logic [4:0]  tg;
        int          lat;
        v[0] = '{OP_FEQ, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};
        v[1] = '{OP_FEQ, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1};
        v[2] = '{OP_FLE, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1};
        v[3] = '{OP_FLT, 32'h3F800000, 32'hFFC00000, 1'b0, 1'b1};
        v[4] = '{OP_FEQ, 32'h3F800000, 32'hFF800001, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, 5'(i + 16), y, nv, tg, lat);
            checks++;
            if (y !== {31'b0, v[i].y} || nv !== v[i].nv || tg !== 5'(i + 16)) begin
                errors++;
                $display("FAIL nan[%0d]: got y=%0h nv=%0b tag=%0d, want y=%0h nv=%0b tag=%0d",
                         i, y, nv, tg, {31'b0, v[i].y}, v[i].nv, i + 16);
            end
        end
    endtask

    task automatic test_reserved();
        logic [31:0] y;
        logic        nv;
        logic [4:0]  tg;
        int          lat;
        run_op(OP_RSV, 32'h3F800000, 32'h3F800000, 5'd21, y, nv, tg, lat);
        checks++;
        if (y !== 32'h0 || nv !== 1'b0 || tg !== 5'd21) begin
            errors++;
            $display("FAIL reserved_equal: got y=%0h nv=%0b tag=%0d, want y=0 nv=0 tag=21", y, nv, tg);
        end
        run_op(OP_RSV, 32'h7F800001, 32'h3F800000, 5'd22, y, nv, tg, lat);
        checks++;
        if (y !== 32'h0 || nv !== 1'b0 || tg !== 5'd22) begin
            errors++;
            $display("FAIL reserved_snan: got y=%0h nv=%0b tag=%0d, want y=0 nv=0 tag=22", y, nv, tg);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[4];
        logic [31:0] xa[4];
        logic [31:0] xb[4];
        logic        ey[4];
        int          ret_cyc[4];
        int          p = 0;
        int          n = 0;
        int          hold = 3;
        bit          first = 0;
        bit          stalled = 0;
        bit          stable_ok = 1;
        logic [31:0] y0 = '0;
        ops = '{OP_FEQ, OP_FLT, OP_FLE, OP_FLT};
        xa  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h80000000};
        xb  = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000};
        ey  = '{1'b1, 1'b0, 1'b1, 1'b0};
        ret_cyc = '{-1, -1, -1, -1};
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (out_valid && !first) begin
                first = 1;
                y0    = out_y;
            end
            if (first && hold > 0) begin
                out_ready = 1'b0;
                hold--;
                if (!(out_valid === 1'b1 && out_tag === 5'd0 && out_y === y0)) stable_ok = 0;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_tag !== 5'(n) || out_y !== {31'b0, ey[n]} || out_nv !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got tag=%0d y=%0h nv=%0b, want tag=%0d y=%0h nv=0",
                             n, out_tag, out_y, out_nv, n, {31'b0, ey[n]});
                end
                ret_cyc[n] = c;
                n++;
            end
            if (p < 4) begin
                in_valid = 1'b1;
                in_op    = ops[p];
                in_x1    = xa[p];
                in_x2    = xb[p];
                in_tag   = 5'(p);
                if (in_ready) p++;
                else stalled = 1;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 4", n);
        end
        checks++;
        if (!stable_ok || stalled !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: got stable=%0b stalled=%0b, want stable=1 stalled=1",
                     stable_ok, stalled);
        end
        checks++;
        if (ret_cyc[0] !== 5 || ret_cyc[1] !== 6 || ret_cyc[2] !== 7 || ret_cyc[3] !== 8) begin
            errors++;
            $display("FAIL b2b_timing: got retire cycles %0d %0d %0d %0d, want 5 6 7 8",
                     ret_cyc[0], ret_cyc[1], ret_cyc[2], ret_cyc[3]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%0b after last result, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y;
        logic        nv;
        logic [4:0]  tg;
        int          lat;
        bit          seen = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_FEQ;
        in_x1     = 32'h3F800000;
        in_x2     = 32'h3F800000;
        in_tag    = 5'd5;
        @(negedge clk);
        in_op  = OP_FLT;
        in_x1  = 32'h40000000;
        in_tag = 5'd6;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_inflight: got out_valid=%0b before reset, want 1", out_valid);
        end
        rst    = 1'b1;
        in_tag = 5'd7;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 32'h0 || out_tag !== 5'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_clear: got valid=%0b y=%0h tag=%0d in_ready=%0b, want 0 0 0 1",
                     out_valid, out_y, out_tag, in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ghost: got a result after reset, want none");
        end
        run_op(OP_FLT, 32'hBF800000, 32'h3F800000, 5'd9, y, nv, tg, lat);
        checks++;
        if (lat !== 2 || y !== 32'h1 || nv !== 1'b0 || tg !== 5'd9) begin
            errors++;
            $display("FAIL rst_mid_after: got lat=%0d y=%0h nv=%0b tag=%0d, want lat=2 y=1 nv=0 tag=9",
                     lat, y, nv, tg);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_zero();
        test_ordering();
        test_nan();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
